// File: rtl/core_lsu.sv
// Load/store unit: turns a LOAD/STORE issue into a single valid/ready bus request with a
// separate response phase, then aligns and extends returned load data.
module core_lsu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_cmem_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   reg_rdata1_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   reg_rdata2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        fault_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [XLEN/8-1:0] dmem_strb_o,
    output logic              dmem_we_o,
    output logic              dmem_valid_o,
    input  logic              dmem_ready_i,
    input  logic              dmem_rvalid_i,
    input  logic              dmem_err_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OffW = $clog2(NB);
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e            state_q;
    logic              valid_q, we_q, done_q, is_load_q, uns_q;
    logic [1:0]        fault_q, size_q;
    logic [OffW-1:0]   off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, load_data_q;
    logic [NB-1:0]     strb_q;

    // Accept-time decode
    logic [XLEN-1:0]   sum;
    logic [ADDR_W-1:0] ea;
    logic [OffW-1:0]   ea_off;
    logic [3:0]        nbytes;
    logic [NB-1:0]     size_mask;
    logic              is_load, is_store, illegal, misaligned;

    always_comb begin
        sum      = reg_rdata1_i + imm_i;
        ea       = sum[ADDR_W-1:0];
        ea_off   = ea[OffW-1:0];
        is_load  = (opcode_i == OpLoad);
        is_store = (opcode_i == OpStore);
        nbytes   = 4'd1 << funct3_i[1:0];
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (i < int'(nbytes));
        end
        if (is_load) begin
            illegal = (funct3_i == 3'd7) ||
                      ((XLEN == 32) && ((funct3_i == 3'd3) || (funct3_i == 3'd6)));
        end else begin
            illegal = funct3_i[2] || ((XLEN == 32) && (funct3_i == 3'd3));
        end
        // Only meaningful for legal sizes, which never exceed the bus width
        misaligned = (ea_off & OffW'(nbytes - 4'd1)) != '0;
    end

    // Response-time load alignment and extension
    logic [XLEN-1:0] rshift, load_ext;
    logic [3:0]      nb_q;
    logic            sign;

    always_comb begin
        rshift = dmem_rdata_i >> {off_q, 3'b000};
        nb_q   = 4'd1 << size_q;
        unique case (size_q)
            2'd0:    sign = rshift[7];
            2'd1:    sign = rshift[15];
            2'd2:    sign = rshift[31];
            default: sign = rshift[XLEN-1];
        endcase
        for (int i = 0; i < NB; i++) begin
            load_ext[8*i +: 8] = (i < int'(nb_q)) ? rshift[8*i +: 8] : {8{sign & ~uns_q}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            is_load_q   <= 1'b0;
            uns_q       <= 1'b0;
            fault_q     <= 2'd0;
            size_q      <= 2'd0;
            off_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            load_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (c_cmem_i && (is_load || is_store)) begin
                        off_q     <= ea_off;
                        size_q    <= funct3_i[1:0];
                        uns_q     <= funct3_i[2];
                        is_load_q <= is_load;
                        if (illegal || misaligned) begin
                            fault_q <= illegal ? 2'd2 : 2'd1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            fault_q <= 2'd0;
                            valid_q <= 1'b1;
                            addr_q  <= ea;
                            wdata_q <= reg_rdata2_i << {ea_off, 3'b000};
                            strb_q  <= size_mask << ea_off;
                            we_q    <= is_store;
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (dmem_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (dmem_rvalid_i) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                        if (dmem_err_i) begin
                            fault_q <= 2'd3;
                        end else if (is_load_q) begin
                            load_data_q <= load_ext;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign load_data_o  = load_data_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_strb_o  = strb_q;
    assign dmem_we_o    = we_q;
    assign dmem_valid_o = valid_q;
endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: an XLEN=32 and an XLEN=64 instance, expected completions
// queued at issue and compared when DONE appears.
module tb_core_lsu;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  fault;
        logic [63:0] ld;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // XLEN=32 instance
    logic        c32 = 0, busy32, done32, we32, val32, rdy32 = 0, rv32 = 0, err32 = 0;
    logic [6:0]  op32 = 0;
    logic [2:0]  f3_32 = 0;
    logic [31:0] rs1_32 = 0, imm32 = 0, rs2_32 = 0, ld32, wd32, rd32 = 0, addr32;
    logic [1:0]  fault32;
    logic [3:0]  strb32;

    core_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .c_cmem_i(c32), .opcode_i(op32), .funct3_i(f3_32),
        .reg_rdata1_i(rs1_32), .imm_i(imm32), .reg_rdata2_i(rs2_32),
        .busy_o(busy32), .done_o(done32), .fault_o(fault32), .load_data_o(ld32),
        .dmem_addr_o(addr32), .dmem_wdata_o(wd32), .dmem_strb_o(strb32), .dmem_we_o(we32),
        .dmem_valid_o(val32), .dmem_ready_i(rdy32), .dmem_rvalid_i(rv32),
        .dmem_err_i(err32), .dmem_rdata_i(rd32)
    );

    // XLEN=64 instance
    logic        c64 = 0, busy64, done64, we64, val64, rdy64 = 0, rv64 = 0, err64 = 0;
    logic [6:0]  op64 = 0;
    logic [2:0]  f3_64 = 0;
    logic [63:0] rs1_64 = 0, imm64 = 0, rs2_64 = 0, ld64, wd64, rd64 = 0;
    logic [31:0] addr64;
    logic [1:0]  fault64;
    logic [7:0]  strb64;

    core_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .c_cmem_i(c64), .opcode_i(op64), .funct3_i(f3_64),
        .reg_rdata1_i(rs1_64), .imm_i(imm64), .reg_rdata2_i(rs2_64),
        .busy_o(busy64), .done_o(done64), .fault_o(fault64), .load_data_o(ld64),
        .dmem_addr_o(addr64), .dmem_wdata_o(wd64), .dmem_strb_o(strb64), .dmem_we_o(we64),
        .dmem_valid_o(val64), .dmem_ready_i(rdy64), .dmem_rvalid_i(rv64),
        .dmem_err_i(err64), .dmem_rdata_i(rd64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_compare(input string tag, input logic [1:0] fault,
                                   input logic [63:0] ld, input int lat);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_fault"}, {62'd0, fault}, {62'd0, e.fault});
            check({tag, "_load_data"}, ld, e.ld);
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        end
    endtask

    // One XLEN=32 operation; the bus side waits rdy_wait cycles before READY, then
    // answers with RVALID in the first RESP cycle.
    task automatic do32(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] rs2, input int rdy_wait,
                        input logic [31:0] rdata, input logic err,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_strb, input logic e_we,
                        input logic [1:0] e_fault, input logic [31:0] e_ld,
                        input int e_lat, input logic poke_done);
        int k = 0;
        int vcnt = 0;
        logic seen = 1'b0;
        @(negedge clk);
        c32 = 1; op32 = op; f3_32 = f3; rs1_32 = base; imm32 = imm; rs2_32 = rs2;
        exp_q.push_back('{e_fault, {32'd0, e_ld}, e_lat});
        @(posedge clk);
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            c32 = 0; rv32 = 0; rdy32 = 0;
            if (done32) begin
                seen = 1'b1;
                check({tag, "_valid_at_done"}, {63'd0, val32}, 64'd0);
                pop_and_compare(tag, fault32, {32'd0, ld32}, k);
                if (poke_done) begin
                    c32 = 1; op32 = LOAD; f3_32 = 3'd2; rs1_32 = 32'h100; imm32 = 0;
                end
            end else if (val32) begin
                check({tag, "_addr"}, {32'd0, addr32}, {32'd0, e_addr});
                check({tag, "_wdata"}, {32'd0, wd32}, {32'd0, e_wdata});
                check({tag, "_strb"}, {60'd0, strb32}, {60'd0, e_strb});
                check({tag, "_we"}, {63'd0, we32}, {63'd0, e_we});
                if (vcnt >= rdy_wait) begin
                    rdy32 = 1;
                end else begin
                    // Early RVALID and a fresh issue strobe must both be ignored in REQ
                    rv32 = 1; rd32 = rdata; err32 = err;
                    c32 = 1; op32 = LOAD; f3_32 = 3'd2; rs1_32 = 0; imm32 = 0;
                end
                vcnt++;
            end else if (busy32) begin
                rv32 = 1; rd32 = rdata; err32 = err;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        c32 = 0;
        check({tag, "_idle_after"}, {62'd0, busy32, done32}, 64'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, val32}, 64'd0);
        check("rst_busy", {63'd0, busy32}, 64'd0);
        check("rst_outs", {31'd0, done32, we32, fault32, strb32, 24'd0}, 64'd0);
        check("rst_addr_wdata", {addr32, wd32}, 64'd0);
        check("rst_load_data", {32'd0, ld32}, 64'd0);
        @(posedge clk);
        #1 rst = 0;

        do32("lb", LOAD, 3'd0, 32'h1000, 32'd3, 32'h12345678, 0, 32'h80AA5511, 0,
             32'h1003, 32'h78000000, 4'b1000, 0, 2'd0, 32'hFFFFFF80, 3, 0);
        do32("sh", STORE, 3'd1, 32'h2000, 32'd2, 32'h0000BEEF, 0, 32'hDEADBEEF, 0,
             32'h2002, 32'hBEEF0000, 4'b1100, 1, 2'd0, 32'hFFFFFF80, 3, 0);
        do32("lw_mis", LOAD, 3'd2, 32'h1000, 32'd2, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd1, 32'hFFFFFF80, 1, 1);
        do32("lwu32", LOAD, 3'd6, 32'h1000, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd2, 32'hFFFFFF80, 1, 0);
        do32("lw_err", LOAD, 3'd2, 32'h3000, 32'd4, 32'hCAFEF00D, 5, 32'h11111111, 1,
             32'h3004, 32'hCAFEF00D, 4'b1111, 0, 2'd3, 32'hFFFFFF80, 8, 0);
        do32("lhu", LOAD, 3'd5, 32'h10, 32'd2, 32'd0, 0, 32'h80010000, 0,
             32'h12, 32'd0, 4'b1100, 0, 2'd0, 32'h00008001, 3, 0);
        do32("lh", LOAD, 3'd1, 32'h10, 32'd2, 32'd0, 0, 32'h80010000, 0,
             32'h12, 32'd0, 4'b1100, 0, 2'd0, 32'hFFFF8001, 3, 0);
        do32("lbu_wrap", LOAD, 3'd4, 32'hFFFFFFFF, 32'd2, 32'h000000AB, 0, 32'h00009C00, 0,
             32'h1, 32'h0000AB00, 4'b0010, 0, 2'd0, 32'h0000009C, 3, 0);
        do32("sw_wait", STORE, 3'd2, 32'h4000, 32'hFFFFFFFC, 32'h01020304, 2, 32'hFFFFFFFF, 0,
             32'h3FFC, 32'h01020304, 4'b1111, 1, 2'd0, 32'h0000009C, 5, 0);
        do32("sh_mis", STORE, 3'd1, 32'h2001, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd1, 32'h0000009C, 1, 0);
        do32("st_f3_4", STORE, 3'd4, 32'h1000, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd2, 32'h0000009C, 1, 0);
        do32("sd32", STORE, 3'd3, 32'h1000, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd2, 32'h0000009C, 1, 0);
        do32("ld32", LOAD, 3'd3, 32'h1000, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd2, 32'h0000009C, 1, 0);
        do32("ld_f3_7", LOAD, 3'd7, 32'h1000, 32'd0, 32'd0, 0, 32'd0, 0,
             32'd0, 32'd0, 4'd0, 0, 2'd2, 32'h0000009C, 1, 0);

        // Non-memory opcode is not accepted
        @(negedge clk);
        c32 = 1; op32 = 7'b0110011; f3_32 = 3'd2; rs1_32 = 32'h1000; imm32 = 0;
        @(negedge clk);
        c32 = 0;
        check("alu_op_ignored", {62'd0, busy32, val32}, 64'd0);

        // XLEN=64 LHU at offset 6
        @(negedge clk);
        c64 = 1; op64 = LOAD; f3_64 = 3'd5; rs1_64 = 64'h1000; imm64 = 64'd6; rs2_64 = 0;
        exp_q.push_back('{2'd0, 64'h000000000000F00D, 3});
        @(posedge clk);
        #1 c64 = 0;
        @(negedge clk);
        check("lhu64_valid", {63'd0, val64}, 64'd1);
        check("lhu64_addr", {32'd0, addr64}, 64'h1006);
        check("lhu64_strb", {56'd0, strb64}, 64'hC0);
        rdy64 = 1;
        @(negedge clk);
        rdy64 = 0;
        rv64 = 1; rd64 = 64'hF00D_0000_0000_0000;
        @(negedge clk);
        rv64 = 0;
        check("lhu64_done", {63'd0, done64}, 64'd1);
        pop_and_compare("lhu64", fault64, ld64, 3);

        // XLEN=64 LD, reset pulse while waiting in RESP
        @(negedge clk);
        c64 = 1; op64 = LOAD; f3_64 = 3'd3; rs1_64 = 64'h2000; imm64 = 0;
        @(posedge clk);
        #1 c64 = 0;
        @(negedge clk);
        check("ld64_strb", {55'd0, val64, strb64}, {55'd0, 1'b1, 8'hFF});
        rdy64 = 1;
        @(negedge clk);
        rdy64 = 0;
        check("ld64_in_resp", {62'd0, busy64, val64}, 64'd2);
        rst = 1;
        #1;
        check("rst_mid_state", {59'd0, busy64, val64, done64, we64, |strb64}, 64'd0);
        check("rst_mid_fault_addr", {30'd0, fault64, addr64}, 64'd0);
        check("rst_mid_data", ld64 | wd64, 64'd0);
        @(negedge clk);
        rst = 0;
        rv64 = 1; rd64 = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        rv64 = 0;
        check("late_rvalid_ignored", {62'd0, busy64, done64}, 64'd0);
        check("late_rvalid_data", ld64, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/register width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning bus address width, at most XLEN.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 C_CMEM  in  1  start strobe from central control.
REQ-007 OPCODE  in  7  instruction opcode.
REQ-008 FUNCT3  in  3  load/store size and sign field.
REQ-009 REG_RDATA1  in  XLEN  base register.
REQ-010 IMM  in  XLEN  sign-extended offset.
REQ-011 REG_RDATA2  in  XLEN  store data.
REQ-012 BUSY  out  1  high in any state other than IDLE.
REQ-013 DONE  out  1  one-cycle completion pulse.
REQ-014 FAULT  out  2  fault cause: 0 none, 1 misaligned, 2 illegal funct3, 3 bus error; valid with DONE.
REQ-015 LOAD_DATA  out  XLEN  aligned, extended load result; valid with DONE.
REQ-016 DMEM_ADDR / DMEM_WDATA / DMEM_STRB / DMEM_WE  out  ADDR_W / XLEN / XLEN/8 / 1  bus request fields.
REQ-017 DMEM_VALID  out  1  request valid; DMEM_READY  in  1  request accepted.
REQ-018 DMEM_RVALID / DMEM_ERR / DMEM_RDATA  in  1 / 1 / XLEN  response valid, response error, read data.

Function
REQ-019 SHALL implement the states IDLE, REQ, RESP and DONE.
REQ-020 IDLE: on C_CMEM=1 with OPCODE LOAD (0000011) or STORE (0100011), SHALL register the operation and go to REQ; C_CMEM with any other opcode, or with BUSY=1, SHALL be ignored.
REQ-021 Effective address SHALL be (REG_RDATA1+IMM) truncated to ADDR_W bits; overflow wraps silently.
REQ-022 Size SHALL be taken from FUNCT3[1:0]: B=1, H=2, W=4, D=8 bytes; D is legal only when XLEN=64.
REQ-023 Load FUNCT3 6 SHALL be legal only when XLEN=64; load 7, load 3 at XLEN=32, any store FUNCT3>=4, and store 3 at XLEN=32 SHALL give FAULT=2.
REQ-024 A misaligned access (address not a multiple of size) SHALL give FAULT=1; a fault detected at accept SHALL skip REQ and RESP and go directly to DONE, with no DMEM_VALID issued.
REQ-025 DMEM_STRB SHALL be the size mask shifted left by off = addr mod (XLEN/8); DMEM_WDATA SHALL be REG_RDATA2 shifted left by 8*off; DMEM_WE=1 for stores only.
REQ-026 REQ: DMEM_VALID=1 and all DMEM_* outputs stable until a rising edge with DMEM_READY=1, then go to RESP.
REQ-027 DMEM_VALID SHALL NOT drop before acceptance.
REQ-028 RESP: wait for DMEM_RVALID=1, for both loads and stores; DMEM_RVALID in any other state SHALL be ignored.
REQ-029 On RVALID with DMEM_ERR=1: FAULT=3 and LOAD_DATA unchanged; on RVALID with DMEM_ERR=0, a load SHALL capture DMEM_RDATA >> 8*off, keep the low size bytes, and sign-extend (FUNCT3[2]=0) or zero-extend (FUNCT3[2]=1) to XLEN.
REQ-030 A store SHALL leave LOAD_DATA unchanged.
REQ-031 DONE SHALL last one cycle, then return to IDLE.
REQ-032 C_CMEM asserted during the DONE cycle SHALL be ignored.
REQ-033 Latency with zero-wait bus: C_CMEM at edge N, DMEM_VALID in cycle N+1, DONE in cycle N+3 when READY and RVALID each arrive in their first eligible cycle.
REQ-034 All outputs SHALL be registered except BUSY, which is decoded from state.

Reset
REQ-035 RST=1 SHALL immediately force IDLE with DMEM_VALID=0, DMEM_WE=0, DMEM_STRB=0, DMEM_ADDR=0, DMEM_WDATA=0, DONE=0, FAULT=0 and LOAD_DATA=0, including mid-transaction; any outstanding response is then ignored.
REQ-036 The first operation SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-037 XLEN=32: LB with base 0x1000, IMM 3, RDATA 0x80AA5511 -> STRB 1000, LOAD_DATA 0xFFFFFF80, FAULT 0, DONE at N+3.
REQ-038 XLEN=32: SH with base 0x2000, IMM 2, RDATA2 0x0000BEEF -> ADDR 0x2002, STRB 1100, WDATA 0xBEEF0000, WE 1.
REQ-039 LW with address 0x1002 -> FAULT 1, DONE at N+1, DMEM_VALID never high; LWU at XLEN=32 -> FAULT 2.
REQ-040 DMEM_READY held low 5 cycles then DMEM_ERR=1 on RVALID -> request fields stable for all 5 cycles, FAULT 3, LOAD_DATA unchanged.
REQ-041 XLEN=64: LHU with address 0x...06, RDATA 0xF00D_0000_0000_0000 -> STRB 0xC0, LOAD_DATA 0xF00D; RST pulse in RESP -> IDLE with VALID 0, late RVALID ignored.
